// File: rtl/spi_tx_sequencer.sv
// SPI mode-0 transmit engine fed by a word FIFO. Words are shifted out MSB-first,
// back-to-back words share one chip-select window, and CSX is released with a
// guaranteed high gap once the queue drains.
module spi_tx_sequencer #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CLKDIV = 4,
    parameter int unsigned CS_GAP = 2
) (
    input  logic                       CLK_100MHz,
    input  logic                       RST_N,
    input  logic                       WR,
    input  logic [WIDTH-1:0]           WR_DATA,
    input  logic                       WR_DC,
    output logic                       FULL,
    output logic                       EMPTY,
    output logic [$clog2(DEPTH+1)-1:0] COUNT,
    output logic                       OVERFLOW,
    output logic                       SCK,
    output logic                       SDI,
    output logic                       CSX,
    output logic                       DC,
    output logic                       BUSY,
    output logic                       DONE
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned BW = $clog2(WIDTH);
    localparam int unsigned DW = $clog2(CLKDIV + 1);
    localparam int unsigned GW = $clog2(CS_GAP + 1);

    localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
    localparam logic [BW-1:0] BitLast = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DivLast = DW'(CLKDIV - 1);
    localparam logic [GW-1:0] GapLast = GW'(CS_GAP - 1);

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StGap} state_e;

    // FIFO storage: {dc, data} per entry
    logic [WIDTH:0]  mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [WIDTH:0]  head;
    logic            push, pop, full, empty;

    state_e          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic            sck_q, sck_d, csx_q, csx_d, dc_q, dc_d, done_q, done_d;

    assign full  = (count_q == DepthC);
    assign empty = (count_q == '0);
    assign push  = WR && !full;
    assign head  = mem_q[rd_ptr_q];

    // FIFO payload write; no reset needed since pointers define validity
    always_ff @(posedge CLK_100MHz) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {WR_DC, WR_DATA};
        end
    end

    // Serialiser FSM next-state; pop is asserted whenever a new word is loaded
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        sck_d   = sck_q;
        csx_d   = csx_q;
        dc_d    = dc_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                sck_d = 1'b0;
                csx_d = 1'b1;
                pop   = !empty;
            end
            StLow: begin
                if (div_q == DivLast) begin
                    div_d   = '0;
                    sck_d   = 1'b1;
                    state_d = StHigh;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            StHigh: begin
                if (div_q == DivLast) begin
                    div_d = '0;
                    sck_d = 1'b0;
                    if (bit_q != BitLast) begin
                        shift_d = {shift_q[WIDTH-2:0], 1'b0};
                        bit_d   = bit_q + BW'(1);
                        state_d = StLow;
                    end else begin
                        done_d = 1'b1;
                        pop    = !empty;
                        if (empty) begin
                            csx_d   = 1'b1;
                            gap_d   = '0;
                            state_d = StGap;
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        // Load a fresh word: from IDLE or as a burst continuation after the last bit
        if (pop) begin
            shift_d = head[WIDTH-1:0];
            dc_d    = head[WIDTH];
            csx_d   = 1'b0;
            bit_d   = '0;
            div_d   = '0;
            state_d = StLow;
        end
    end

    // FIFO bookkeeping next-state; simultaneous push and pop leave the count unchanged
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        ovf_d    = ovf_q | (WR && full);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLK_100MHz) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= StIdle;
            div_q    <= '0;
            gap_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            sck_q    <= 1'b0;
            csx_q    <= 1'b1;
            dc_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            div_q    <= div_d;
            gap_q    <= gap_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            sck_q    <= sck_d;
            csx_q    <= csx_d;
            dc_q     <= dc_d;
            done_q   <= done_d;
        end
    end

    assign FULL     = full;
    assign EMPTY    = empty;
    assign COUNT    = count_q;
    assign OVERFLOW = ovf_q;
    assign SCK      = sck_q;
    assign SDI      = shift_q[WIDTH-1];
    assign CSX      = csx_q;
    assign DC       = dc_q;
    assign BUSY     = (state_q != StIdle);
    assign DONE     = done_q;

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Directed bench for spi_tx_sequencer: a negedge monitor reassembles words from
// SCK rises and measures CSX windows; the stimulus checks against hand-computed values.
module tb_spi_tx_sequencer;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned CLKDIV   = 2;
    localparam int unsigned CS_GAP   = 2;
    localparam int unsigned WORD_CYC = 2 * CLKDIV * WIDTH;  // 32

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_dc = 1'b0;
    logic       full, empty, overflow, sck, sdi, csx, dc, busy, done;
    logic [2:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_tx_sequencer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CLKDIV(CLKDIV),
        .CS_GAP(CS_GAP)
    ) u_dut (
        .CLK_100MHz(clk),
        .RST_N     (rst_n),
        .WR        (wr),
        .WR_DATA   (wr_data),
        .WR_DC     (wr_dc),
        .FULL      (full),
        .EMPTY     (empty),
        .COUNT     (count),
        .OVERFLOW  (overflow),
        .SCK       (sck),
        .SDI       (sdi),
        .CSX       (csx),
        .DC        (dc),
        .BUSY      (busy),
        .DONE      (done)
    );

    // Monitor: slave-side capture on SCK rises plus CSX window lengths
    int         done_cnt = 0, rise_cnt = 0, bit_cnt = 0;
    int         low_run = 0, high_run = 0, last_low_len = 0, last_high_len = 0;
    logic       sck_prev = 1'b0, csx_prev = 1'b1;
    logic [7:0] sh = 8'h00;
    logic [8:0] rx_q [$];

    always @(negedge clk) begin
        if (!rst_n) begin
            bit_cnt <= 0;
            sh      <= 8'h00;
        end else begin
            if (done) done_cnt <= done_cnt + 1;
            if (sck && !sck_prev) begin
                rise_cnt <= rise_cnt + 1;
                sh       <= {sh[6:0], sdi};
                if (bit_cnt == 7) begin
                    rx_q.push_back({dc, sh[6:0], sdi});
                    bit_cnt <= 0;
                end else begin
                    bit_cnt <= bit_cnt + 1;
                end
            end
        end
        if (!csx) low_run <= low_run + 1;
        else      high_run <= high_run + 1;
        if (csx && !csx_prev) begin
            last_low_len <= low_run;
            low_run      <= 0;
        end
        if (!csx && csx_prev) begin
            last_high_len <= high_run;
            high_run      <= 0;
        end
        sck_prev <= sck;
        csx_prev <= csx;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (i < budget) begin
            tick();
            i++;
            if (done === 1'b1) break;
        end
        if (done !== 1'b1) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while (i < budget && busy !== 1'b0) begin
            tick();
            i++;
        end
        check_eq("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    task automatic expect_rx(input string tag, input logic [8:0] exp);
        logic [31:0] got;
        if (rx_q.size() == 0) got = 32'hDEAD;
        else got = {23'd0, rx_q.pop_front()};
        check_eq(tag, got, {23'd0, exp});
    endtask

    task automatic write_word(input logic [7:0] d, input logic c);
        wr      = 1'b1;
        wr_data = d;
        wr_dc   = c;
        tick();
        wr      = 1'b0;
    endtask

    initial begin
        int d0;
        int r0;

        // Reset state
        repeat (3) tick();
        check_eq("rst_count", {29'd0, count}, 32'd0);
        check_eq("rst_flags", {25'd0, empty, full, overflow, sck, sdi, csx, dc},
                 {25'd0, 7'b1000010});
        check_eq("rst_busy_done", {30'd0, busy, done}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single word 0xA5, DC=0
        d0 = done_cnt;
        write_word(8'hA5, 1'b0);
        check_eq("s_empty_after_push", {31'd0, empty}, 32'd0);
        check_eq("s_csx_before_pop", {31'd0, csx}, 32'd1);
        tick();
        check_eq("s_csx_pop", {31'd0, csx}, 32'd0);
        check_eq("s_sdi_msb", {31'd0, sdi}, 32'd1);
        tick();
        check_eq("s_sck_low", {31'd0, sck}, 32'd0);
        tick();
        check_eq("s_sck_first_rise", {31'd0, sck}, 32'd1);
        wait_done(WORD_CYC + 4);
        check_eq("s_done_edge", {30'd0, csx, sck}, 32'd2);
        tick();
        check_eq("s_busy_in_gap", {31'd0, busy}, 32'd1);
        tick();
        check_eq("s_idle_after_gap", {30'd0, busy, csx}, 32'd1);
        check_eq("s_low_len", last_low_len, WORD_CYC);
        check_eq("s_done_count", done_cnt - d0, 32'd1);
        expect_rx("s_word", 9'h0A5);
        check_eq("s_rx_empty", rx_q.size(), 32'd0);

        // Burst of three words in one CSX window
        d0 = done_cnt;
        write_word(8'hA5, 1'b0);
        write_word(8'h5A, 1'b1);
        write_word(8'hFF, 1'b1);
        wait_done(WORD_CYC + 8);
        check_eq("b_dc_switch", {30'd0, dc, csx}, 32'd2);
        wait_done(WORD_CYC + 4);
        check_eq("b_done2", {30'd0, dc, csx}, 32'd2);
        wait_done(WORD_CYC + 4);
        check_eq("b_done3_csx", {31'd0, csx}, 32'd1);
        wait_idle(CS_GAP + 4);
        check_eq("b_low_len", last_low_len, 3 * WORD_CYC);
        check_eq("b_done_count", done_cnt - d0, 32'd3);
        expect_rx("b_word0", 9'h0A5);
        expect_rx("b_word1", 9'h15A);
        expect_rx("b_word2", 9'h1FF);
        check_eq("b_rx_empty", rx_q.size(), 32'd0);

        // Overflow: six writes, the first is popped, four fill the FIFO, last dropped
        for (int i = 0; i < 6; i++) begin
            write_word(8'(i + 1), i[0]);
            wr = 1'b1;
        end
        wr = 1'b0;
        check_eq("o_full", {31'd0, full}, 32'd1);
        check_eq("o_overflow", {31'd0, overflow}, 32'd1);
        check_eq("o_count", {29'd0, count}, 32'd4);
        repeat (5) wait_done(WORD_CYC + 8);
        wait_idle(CS_GAP + 4);
        for (int i = 0; i < 5; i++) begin
            logic [8:0] e;
            e = {i[0], 8'(i + 1)};
            expect_rx("o_word", e);
        end
        check_eq("o_rx_empty", rx_q.size(), 32'd0);

        // Push coincident with a burst pop at COUNT=2
        write_word(8'h31, 1'b1);
        write_word(8'h32, 1'b0);
        write_word(8'h33, 1'b1);
        check_eq("p_count_pre", {29'd0, count}, 32'd2);
        repeat (30) tick();
        wr      = 1'b1;
        wr_data = 8'h34;
        wr_dc   = 1'b0;
        tick();
        wr      = 1'b0;
        check_eq("p_done_on_pop", {31'd0, done}, 32'd1);
        check_eq("p_count_same", {29'd0, count}, 32'd2);
        repeat (3) wait_done(WORD_CYC + 8);
        wait_idle(CS_GAP + 4);
        expect_rx("p_word0", 9'h131);
        expect_rx("p_word1", 9'h032);
        expect_rx("p_word2", 9'h133);
        expect_rx("p_word3", 9'h034);
        check_eq("p_rx_empty", rx_q.size(), 32'd0);
        check_eq("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Reset after three SCK rises of 0xA5
        d0 = done_cnt;
        r0 = rise_cnt;
        write_word(8'hA5, 1'b0);
        for (int i = 0; i < 100 && (rise_cnt - r0) < 3; i++) tick();
        check_eq("r_rises", rise_cnt - r0, 32'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("r_pins", {30'd0, csx, sck}, 32'd2);
        check_eq("r_count", {29'd0, count}, 32'd0);
        check_eq("r_flags", {29'd0, done, busy, overflow}, 32'd0);
        tick();
        check_eq("r_no_done", done_cnt - d0, 32'd0);
        check_eq("r_no_word", rx_q.size(), 32'd0);
        write_word(8'h5A, 1'b1);
        wait_done(WORD_CYC + 8);
        wait_idle(CS_GAP + 4);
        expect_rx("r_clean_word", 9'h15A);

        // Word written on the DONE cycle waits out the gap
        write_word(8'h11, 1'b0);
        wait_done(WORD_CYC + 8);
        write_word(8'h22, 1'b0);
        check_eq("g_queued", {30'd0, count[1:0]}, 32'd1);
        check_eq("g_csx_gap", {31'd0, csx}, 32'd1);
        tick();
        check_eq("g_csx_idle", {31'd0, csx}, 32'd1);
        tick();
        check_eq("g_csx_fall", {31'd0, csx}, 32'd0);
        tick();
        check_eq("g_high_len", last_high_len, CS_GAP + 1);
        wait_done(WORD_CYC + 4);
        wait_idle(CS_GAP + 4);
        expect_rx("g_word0", 9'h011);
        expect_rx("g_word1", 9'h022);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
